// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the combinational result bundle.
package md_unit_pkg;

    // Same encoding the controller drives onto md_op
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } md_res_t;

    // Ops 0..3 occupy the busy period; everything else completes immediately
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational datapath: 64-bit signed/unsigned product and 32-bit
// signed/unsigned quotient+remainder. One divider is shared by DIV and DIVU
// by dividing magnitudes and restoring signs afterwards.
module md_unit_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output md_res_t     o_res
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_sdiv;
    logic               w_dbz;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_a_mag;
    logic        [31:0] w_b_mag;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_q;
    logic        [31:0] w_r;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor is replaced by 1 so the divider never sees it; the
    // result is thrown away at commit anyway.
    assign w_dbz    = (i_b == 32'd0);
    assign w_b_safe = w_dbz ? 32'd1 : i_b;
    assign w_sdiv   = (i_op == OP_DIV);

    assign w_a_mag  = (w_sdiv && i_a[31])      ? (32'd0 - i_a)      : i_a;
    assign w_b_mag  = (w_sdiv && w_b_safe[31]) ? (32'd0 - w_b_safe) : w_b_safe;
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 wraps naturally to 0x80000000 with remainder 0.
    assign w_q = (w_sdiv && (i_a[31] ^ w_b_safe[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r = (w_sdiv && i_a[31])                  ? (32'd0 - w_r_mag) : w_r_mag;

    // Select the result for the requested op
    always_comb begin
        o_res = '0;
        case (md_op_e'(i_op))
            OP_MULT:  begin o_res.hi = w_prod_s[63:32]; o_res.lo = w_prod_s[31:0]; end
            OP_MULTU: begin o_res.hi = w_prod_u[63:32]; o_res.lo = w_prod_u[31:0]; end
            OP_DIV,
            OP_DIVU:  begin o_res.hi = w_r; o_res.lo = w_q; o_res.dbz = w_dbz; end
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit. Holds HI/LO, a two-state FSM and a
// down-counter that models the fixed mult/div latency. The result is computed
// at issue, parked in temp registers and committed as busy falls.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          r_state, w_state;
    logic [CNT_W-1:0]   r_cnt,    w_cnt;
    logic [31:0]        r_hi_tmp, w_hi_tmp;
    logic [31:0]        r_lo_tmp, w_lo_tmp;
    logic               r_dbz,    w_dbz;
    logic [31:0]        r_hi,     w_hi;
    logic [31:0]        r_lo,     w_lo;
    md_res_t            w_res;
    md_op_e             w_op;

    assign w_op = md_op_e'(md_op);

    md_unit_calc u_calc (
        .i_op  (md_op),
        .i_a   (src_a),
        .i_b   (src_b),
        .o_res (w_res)
    );

    // State, counter, temp and architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi_tmp <= '0;
            r_lo_tmp <= '0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_hi_tmp <= w_hi_tmp;
            r_lo_tmp <= w_lo_tmp;
            r_dbz    <= w_dbz;
            r_hi     <= w_hi;
            r_lo     <= w_lo;
        end
    end

    // Next-state: issue in IDLE, count down and commit in RUN.
    // Starts seen while RUN are dropped so nothing in flight is disturbed.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_hi_tmp = r_hi_tmp;
        w_lo_tmp = r_lo_tmp;
        w_dbz    = r_dbz;
        w_hi     = r_hi;
        w_lo     = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (md_start) begin
                    if (is_arith(md_op)) begin
                        w_hi_tmp = w_res.hi;
                        w_lo_tmp = w_res.lo;
                        w_dbz    = w_res.dbz;
                        w_cnt    = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        w_state  = ST_RUN;
                    end else if (w_op == OP_MTHI) begin
                        w_hi = src_a;
                    end else if (w_op == OP_MTLO) begin
                        w_lo = src_a;
                    end
                end
            end
            ST_RUN: begin
                w_cnt = r_cnt - 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt   = '0;
                    w_state = ST_IDLE;
                    if (!r_dbz) begin
                        w_hi = r_hi_tmp;
                        w_lo = r_lo_tmp;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length
// from a 64-bit arithmetic reference model; a negedge monitor pops on each
// completion (busy fall, or HI/LO change while idle).
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on architectural HI/LO
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, qq, rr;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; e.cycles = 5; end
            3'd1: begin pu = 64'(a) * 64'(b); m_hi = pu[63:32]; m_lo = pu[31:0]; e.cycles = 5; end
            3'd2: begin
                if (b != 0) begin qq = sa / sb; rr = sa % sb; m_lo = qq[31:0]; m_hi = rr[31:0]; end
                e.cycles = 10;
            end
            3'd3: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                e.cycles = 10;
            end
            3'd4: begin m_hi = a; e.cycles = 0; end
            3'd5: begin m_lo = a; e.cycles = 0; end
            default: return;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                total++; bad++;
                $display("FAIL busy_timeout act=busy_stuck exp=idle");
                return;
            end
        end
    endtask

    // Legal issue: waits for idle, records expectation, drives one cycle
    task automatic issue(input logic [2:0] op, input logic [31:0] a_in, input logic [31:0] b);
        logic [31:0] a;
        a = a_in;
        wait_idle();
        if (op == 3'd4 && a == m_hi) a = a ^ 32'd1;
        if (op == 3'd5 && a == m_lo) a = a ^ 32'd1;
        model(op, a, b);
        md_start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        md_start = 1'b0;
    endtask

    // Raw drive without expectation (used for starts that must be ignored)
    task automatic issue_raw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        md_start = 1'b0;
    endtask

    // Monitor: counts busy cycles, pops on each visible completion
    logic        pb = 1'b0;
    logic [31:0] ph = 32'd0;
    logic [31:0] pl = 32'd0;
    int          bcnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            pb = 1'b0; ph = hi; pl = lo; bcnt = 0;
        end else begin
            if (busy) begin
                bcnt++;
                if (hi !== ph || lo !== pl) begin
                    total++; bad++;
                    $display("FAIL hilo_while_busy act=%h_%h exp=%h_%h", hi, lo, ph, pl);
                end
            end else if (pb || hi !== ph || lo !== pl) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_update act=%h_%h exp=no_change", hi, lo);
                end else begin
                    me = q.pop_front();
                    chk("sb_hi", hi, me.hi);
                    chk("sb_lo", lo, me.lo);
                    chk("sb_busy_cycles", 32'(bcnt), 32'(me.cycles));
                end
                bcnt = 0;
            end
            pb = busy; ph = hi; pl = lo;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);

        // 1, 2: signed vs unsigned product
        issue(3'd0, 32'hFFFFFFFF, 32'h2); wait_idle();
        chk("t1_hi", hi, 32'hFFFFFFFF); chk("t1_lo", lo, 32'hFFFFFFFE);
        issue(3'd1, 32'hFFFFFFFF, 32'h2); wait_idle();
        chk("t2_hi", hi, 32'h00000001); chk("t2_lo", lo, 32'hFFFFFFFE);

        // 3: signed vs unsigned division
        issue(3'd2, 32'hFFFFFFF9, 32'h2); wait_idle();
        chk("t3_div_hi", hi, 32'hFFFFFFFF); chk("t3_div_lo", lo, 32'hFFFFFFFD);
        issue(3'd3, 32'hFFFFFFF9, 32'h2); wait_idle();
        chk("t3_divu_hi", hi, 32'h1); chk("t3_divu_lo", lo, 32'h7FFFFFFC);

        // Overflow case of signed division
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_idle();
        chk("ovf_hi", hi, 32'h0); chk("ovf_lo", lo, 32'h80000000);

        // 4: divide by zero leaves HI/LO
        issue(3'd4, 32'h11, 32'h0);
        issue(3'd5, 32'h22, 32'h0);
        issue(3'd3, 32'h5, 32'h0); wait_idle();
        chk("t4_hi", hi, 32'h11); chk("t4_lo", lo, 32'h22);

        // 5: MTHI while idle; MTLO during busy is ignored
        issue(3'd4, 32'hDEAD, 32'h0);
        chk("t5_hi", hi, 32'hDEAD); chk("t5_busy", {31'd0, busy}, 32'd0);
        issue(3'd0, 32'd3, 32'd7);
        @(negedge clk);
        issue_raw(3'd5, 32'h1234, 32'h0);
        wait_idle();
        chk("t5_lo", lo, 32'd21);

        // 6: reset in the middle of a DIV
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_hi", hi, 32'd0); chk("t6_lo", lo, 32'd0);
        q.delete(); m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'hFFFFFFFD, 32'd4); wait_idle();
        chk("t6_after_hi", hi, 32'hFFFFFFFF); chk("t6_after_lo", lo, 32'hFFFFFFF4);

        // Randomized mix, including no-ops and illegal starts while busy
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 9));
            issue(op, a, b);
            if (op <= 3'd3 && $urandom_range(0, 2) == 0)
                issue_raw(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
